// File: rtl/wam_game_sequencer_pkg.sv
// Shared definitions for the whack-a-mole game sequencer.
// Covers FSM state encodings, mode one-hot codes, counter width and the mode decoder.
package wam_game_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_SETUP     = 2'd0,
    ST_PLAY      = 2'd1,
    ST_GAME_OVER = 2'd2,
    ST_RESTART   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GM_NORMAL = 2'd0,
    GM_TIMED  = 2'd1,
    GM_DEATH  = 2'd2,
    GM_LEVEL  = 2'd3
  } game_mode_t;

  localparam logic [3:0] MODE_NORMAL = 4'b0001;
  localparam logic [3:0] MODE_TIMED  = 4'b0010;
  localparam logic [3:0] MODE_DEATH  = 4'b0100;
  localparam logic [3:0] MODE_LEVEL  = 4'b1000;

  localparam int         CNT_W   = 6;
  localparam logic [5:0] CNT_MAX = 6'd63;

  // Anything that is not a clean one-hot code plays as a normal game.
  function automatic game_mode_t decode_mode(input logic [3:0] mode);
    game_mode_t m;
    case (mode)
      MODE_TIMED: m = GM_TIMED;
      MODE_DEATH: m = GM_DEATH;
      MODE_LEVEL: m = GM_LEVEL;
      default:    m = GM_NORMAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wam_game_sequencer_sec.sv
// One-second tick generator: prescaler counting 0..CLK_HZ-1 while enabled.
// The tick is a single-cycle strobe in the cycle the prescaler wraps.
module wam_sec_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] L_LAST = W'(CLK_HZ - 1);

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = i_en & (r_cnt == L_LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/wam_game_sequencer.sv
// Whack-a-mole game-flow controller: SETUP/PLAY/GAME_OVER/RESTART FSM plus scoring
// counters (flicks, points, lives, countdown, level) feeding the HEX display path.
module wam_game_sequencer
  import wam_game_sequencer_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int NORMAL_FLICKS   = 25,
  parameter int EXTENDED_FLICKS = 50,
  parameter int TIMED_SECONDS   = 60,
  parameter int HITS_PER_LEVEL  = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_play,
  input  logic [3:0] i_mode,
  input  logic       i_extended,
  input  logic       i_light_on,
  input  logic [3:0] i_light_coord,
  input  logic       i_key_valid,
  input  logic [3:0] i_key,
  output logic [1:0] o_state,
  output logic       o_load_seed,
  output logic       o_clear_n,
  output logic       o_start_game,
  output logic       o_game_over,
  output logic [5:0] o_max_hits,
  output logic [5:0] o_flicks,
  output logic [5:0] o_points,
  output logic [5:0] o_time_left,
  output logic [1:0] o_lives_left,
  output logic [1:0] o_level
);

  localparam logic [5:0] L_NORMAL   = 6'(NORMAL_FLICKS);
  localparam logic [5:0] L_EXTENDED = 6'(EXTENDED_FLICKS);
  localparam logic [5:0] L_SECONDS  = 6'(TIMED_SECONDS);
  localparam logic [5:0] L_HPL_LAST = 6'(HITS_PER_LEVEL - 1);

  state_t     r_state, w_next;
  game_mode_t r_mode_sel, w_mode_now;
  logic [5:0] r_max_hits, r_flicks, r_points, r_time_left, r_lvl_cnt;
  logic [1:0] r_lives, r_level;
  logic       r_play_q, r_light_q, r_key_q, r_scored;
  logic       r_load_seed, r_clear_n, r_start_game, r_game_over;
  logic       w_play_rise, w_flick_end, w_hit, w_end_cond, w_tick, w_in_play, w_in_restart;

  assign w_mode_now   = decode_mode(i_mode);
  assign w_in_play    = (r_state == ST_PLAY);
  assign w_in_restart = (r_state == ST_RESTART);
  assign w_play_rise  = i_play & ~r_play_q;
  assign w_flick_end  = r_light_q & ~i_light_on;
  assign w_hit        = i_key_valid & ~r_key_q & i_light_on & (i_key == i_light_coord) & ~r_scored;

  wam_sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_in_play & (r_mode_sel == GM_TIMED)),
    .i_clr   (w_in_restart),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_end_cond = 1'b0;
    case (r_mode_sel)
      GM_TIMED: w_end_cond = (r_time_left == 6'd0);
      GM_DEATH: w_end_cond = (r_lives == 2'd0) | (r_flicks == r_max_hits);
      default:  w_end_cond = (r_flicks == r_max_hits);
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SETUP:     if (w_play_rise) w_next = ST_RESTART; else w_next = ST_SETUP;
      ST_RESTART:   w_next = ST_PLAY;
      ST_PLAY: begin
        if (w_play_rise)     w_next = ST_RESTART;
        else if (w_end_cond) w_next = ST_GAME_OVER;
        else                 w_next = ST_PLAY;
      end
      ST_GAME_OVER: if (w_play_rise) w_next = ST_RESTART; else w_next = ST_GAME_OVER;
      default:      w_next = ST_SETUP;
    endcase
  end

  // State register with Moore outputs registered from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_SETUP;
      r_load_seed  <= 1'b1;
      r_clear_n    <= 1'b1;
      r_start_game <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_load_seed  <= (w_next == ST_SETUP);
      r_clear_n    <= (w_next != ST_RESTART);
      r_start_game <= (w_next == ST_PLAY);
      r_game_over  <= (w_next == ST_GAME_OVER);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_play_q  <= 1'b0;
      r_light_q <= 1'b0;
      r_key_q   <= 1'b0;
    end else begin
      r_play_q  <= i_play;
      r_light_q <= i_light_on;
      r_key_q   <= i_key_valid;
    end
  end

  // Game configuration follows the switches until play starts, then stays frozen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode_sel <= GM_NORMAL;
      r_max_hits <= L_NORMAL;
    end else if ((r_state == ST_SETUP) || w_in_restart) begin
      r_mode_sel <= w_mode_now;
      r_max_hits <= i_extended ? L_EXTENDED : L_NORMAL;
    end else begin
      r_mode_sel <= r_mode_sel;
      r_max_hits <= r_max_hits;
    end
  end

  // Scoring counters; they only move during PLAY and hold for display otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flicks    <= 6'd0;
      r_points    <= 6'd0;
      r_time_left <= L_SECONDS;
      r_lives     <= 2'd0;
      r_level     <= 2'd0;
      r_lvl_cnt   <= 6'd0;
      r_scored    <= 1'b0;
    end else if (w_in_restart) begin
      r_flicks    <= 6'd0;
      r_points    <= 6'd0;
      r_time_left <= L_SECONDS;
      r_lives     <= (w_mode_now == GM_DEATH) ? 2'd1 : 2'd0;
      r_level     <= 2'd0;
      r_lvl_cnt   <= 6'd0;
      r_scored    <= 1'b0;
    end else if (w_in_play) begin
      if (w_flick_end && (r_flicks < r_max_hits)) r_flicks <= r_flicks + 6'd1;
      if (w_flick_end)  r_scored <= 1'b0;
      else if (w_hit)   r_scored <= 1'b1;
      if (w_hit && (r_points != CNT_MAX)) begin
        r_points <= r_points + 6'd1;
        if (r_mode_sel == GM_LEVEL) begin
          if (r_lvl_cnt == L_HPL_LAST) begin
            r_lvl_cnt <= 6'd0;
            if (r_level != 2'd3) r_level <= r_level + 2'd1;
          end else begin
            r_lvl_cnt <= r_lvl_cnt + 6'd1;
          end
        end
      end
      // A window closing without a scored hit costs the single deathmatch life.
      if ((r_mode_sel == GM_DEATH) && w_flick_end && !r_scored) r_lives <= 2'd0;
      if ((r_mode_sel == GM_TIMED) && w_tick && (r_time_left != 6'd0))
        r_time_left <= r_time_left - 6'd1;
    end else begin
      r_flicks    <= r_flicks;
      r_points    <= r_points;
      r_time_left <= r_time_left;
      r_lives     <= r_lives;
      r_level     <= r_level;
      r_lvl_cnt   <= r_lvl_cnt;
      r_scored    <= r_scored;
    end
  end

  assign o_state      = r_state;
  assign o_load_seed  = r_load_seed;
  assign o_clear_n    = r_clear_n;
  assign o_start_game = r_start_game;
  assign o_game_over  = r_game_over;
  assign o_max_hits   = r_max_hits;
  assign o_flicks     = r_flicks;
  assign o_points     = r_points;
  assign o_time_left  = r_time_left;
  assign o_lives_left = r_lives;
  assign o_level      = r_level;

endmodule

// File: tb/tb_wam_game_sequencer.sv
// Directed self-checking bench for wam_game_sequencer, CLK_HZ=100 to keep timed games short.
module tb_wam_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0;
  logic [3:0] mode = 4'b0001;
  logic       extended = 1'b0;
  logic       light_on = 1'b0;
  logic [3:0] light_coord = 4'd0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic [1:0] state;
  logic       load_seed, clear_n, start_game, game_over;
  logic [5:0] max_hits, flicks, points, time_left;
  logic [1:0] lives_left, level;

  int errors = 0;
  int checks = 0;

  wam_game_sequencer #(.CLK_HZ(100)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_play        (play),
    .i_mode        (mode),
    .i_extended    (extended),
    .i_light_on    (light_on),
    .i_light_coord (light_coord),
    .i_key_valid   (key_valid),
    .i_key         (key),
    .o_state       (state),
    .o_load_seed   (load_seed),
    .o_clear_n     (clear_n),
    .o_start_game  (start_game),
    .o_game_over   (game_over),
    .o_max_hits    (max_hits),
    .o_flicks      (flicks),
    .o_points      (points),
    .o_time_left   (time_left),
    .o_lives_left  (lives_left),
    .o_level       (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic play_pulse();
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
  endtask

  // One lit window: light on, npress key strokes, light off (flick ends on that edge).
  task automatic window(input logic [3:0] coord, input logic [3:0] k, input int npress);
    light_on = 1'b1;
    light_coord = coord;
    key = k;
    tick();
    for (int p = 0; p < npress; p++) begin
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      tick();
    end
    light_on = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_state", state, 0);
    check("rst_load_seed", load_seed, 1);
    check("rst_clear_n", clear_n, 1);
    check("rst_start", start_game, 0);
    check("rst_max_hits", max_hits, 25);
    check("rst_flicks", flicks, 0);
    check("rst_points", points, 0);
    check("rst_time_left", time_left, 60);
    check("rst_lives", lives_left, 0);

    // 2: play held high restarts once, then a full normal game of 25 hits
    play = 1'b1;
    tick();
    check("restart_state", state, 3);
    check("restart_clear_n", clear_n, 0);
    check("restart_load_seed", load_seed, 0);
    tick();
    check("play_state", state, 1);
    check("play_start", start_game, 1);
    check("play_clear_n", clear_n, 1);
    tick();
    check("play_held_state", state, 1);
    play = 1'b0;
    for (int i = 0; i < 25; i++) window(4'(i), 4'(i), 1);
    check("g2_points", points, 25);
    check("g2_flicks", flicks, 25);
    check("g2_state_before_over", state, 1);
    tick();
    check("g2_over_state", state, 2);
    check("g2_game_over", game_over, 1);
    check("g2_start_low", start_game, 0);
    tick();
    check("g2_points_held", points, 25);

    // 3: repeated presses score once, wrong key scores nothing
    play_pulse();
    check("g3_state", state, 1);
    check("g3_points_cleared", points, 0);
    check("g3_flicks_cleared", flicks, 0);
    window(4'd7, 4'd7, 3);
    check("g3_triple_press", points, 1);
    window(4'd5, 4'd6, 1);
    check("g3_wrong_key", points, 1);
    check("g3_flicks", flicks, 2);

    // 4: deathmatch, one hit then a missed window
    mode = 4'b0100;
    play_pulse();
    check("g4_lives_start", lives_left, 1);
    window(4'd3, 4'd3, 1);
    check("g4_lives_after_hit", lives_left, 1);
    window(4'd4, 4'd0, 0);
    check("g4_lives_after_miss", lives_left, 0);
    check("g4_flicks", flicks, 2);
    check("g4_points", points, 1);
    tick();
    check("g4_over", state, 2);

    // 5: timed, extended; countdown of 60 seconds at 100 cycles each
    mode = 4'b0010;
    extended = 1'b1;
    play_pulse();
    check("g5_max_hits", max_hits, 50);
    check("g5_time_start", time_left, 60);
    check("g5_lives", lives_left, 0);
    window(4'd1, 4'd1, 0);
    check("g5_flicks", flicks, 1);
    repeat (97) tick();
    check("g5_time_99", time_left, 60);
    tick();
    check("g5_time_100", time_left, 59);
    repeat (5900) tick();
    check("g5_time_zero", time_left, 0);
    check("g5_still_play", state, 1);
    tick();
    check("g5_over", state, 2);
    tick();
    check("g5_time_held", time_left, 0);

    // 6: level progression, frozen config, restart from PLAY
    mode = 4'b1000;
    extended = 1'b0;
    play_pulse();
    check("g6_max_hits", max_hits, 25);
    extended = 1'b1;
    for (int i = 0; i < 10; i++) window(4'(i), 4'(i), 1);
    check("g6_level1", level, 1);
    check("g6_frozen_max", max_hits, 25);
    for (int i = 0; i < 10; i++) window(4'(i + 3), 4'(i + 3), 1);
    check("g6_level2", level, 2);
    check("g6_points", points, 20);
    check("g6_flicks", flicks, 20);
    check("g6_time_hold", time_left, 60);
    play = 1'b1;
    tick();
    check("g6_restart", state, 3);
    play = 1'b0;
    tick();
    check("g6_replay", state, 1);
    check("g6_pts_clr", points, 0);
    check("g6_lvl_clr", level, 0);
    check("g6_flk_clr", flicks, 0);
    check("g6_max_ext", max_hits, 50);

    // Reset mid-game returns to setup immediately
    window(4'd2, 4'd2, 1);
    check("mid_points", points, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_points", points, 0);
    check("mid_rst_game_over", game_over, 0);
    check("mid_rst_max", max_hits, 25);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
